// File: rtl/console_tx.sv
// console_tx: FIFO-buffered UART transmitter for the core console write port (8N1).
// Define CONSOLE_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1).
module console_tx #(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            console_we,
  input  logic [XLEN-1:0] console_wdata,
  output logic            full,
  output logic            idle,
  output logic            overflow,
  output logic [7:0]      drop_count,
  output logic            tx
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef CONSOLE_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] occ, occ_d;
  logic [7:0]       shift_q;
  logic [CNT_W-1:0] bit_cnt, cnt_d;
  logic [2:0]       bit_idx, idx_d;
  logic             tx_d, push, pop, bit_end, has_data;
  state_t           state, state_d;

  wire unused_wdata = ^{1'b0, console_wdata[XLEN-1:8]};

  // Acceptance uses the registered full, so a same-cycle pop never rescues a write.
  assign push     = console_we & ~full;
  assign has_data = (occ != '0);
  assign bit_end  = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign occ_d    = occ + OCC_W'(push) - OCC_W'(pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    case (state)
      S_IDLE: if (has_data) begin
        pop     = 1'b1;
        state_d = S_START;
      end
      S_START: if (bit_end) state_d = S_DATA;
`ifdef CONSOLE_TX_PARITY_EN
      S_DATA:   if (bit_end && bit_idx == 3'd7) state_d = S_PARITY;
      S_PARITY: if (bit_end) state_d = S_STOP;
`else
      S_DATA:   if (bit_end && bit_idx == 3'd7) state_d = S_STOP;
`endif
      S_STOP: if (bit_end) begin
        if (has_data) begin
          pop     = 1'b1;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_d  = tx;
    cnt_d = bit_end ? '0 : bit_cnt + CNT_W'(1);
    idx_d = bit_idx;
    case (state)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        tx_d  = ~pop;
      end
      S_START: if (bit_end) begin
        tx_d  = shift_q[0];
        idx_d = '0;
      end
      S_DATA: if (bit_end) begin
        if (bit_idx == 3'd7) begin
`ifdef CONSOLE_TX_PARITY_EN
          tx_d = ^shift_q;
`else
          tx_d = 1'b1;
`endif
        end else begin
          idx_d = bit_idx + 3'd1;
          tx_d  = shift_q[bit_idx + 3'd1];
        end
      end
`ifdef CONSOLE_TX_PARITY_EN
      S_PARITY: if (bit_end) tx_d = 1'b1;
`endif
      S_STOP: if (bit_end) tx_d = ~pop;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx         <= 1'b1;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      full       <= 1'b0;
      idle       <= 1'b1;
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      tx      <= tx_d;
      bit_cnt <= cnt_d;
      bit_idx <= idx_d;
      occ     <= occ_d;
      full    <= (occ_d == OCC_W'(FIFO_DEPTH));
      idle    <= (state_d == S_IDLE) && (occ_d == '0);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (console_we && full) begin
        overflow   <= 1'b1;
        drop_count <= sat_inc8(drop_count);
      end
    end
  end

  // Buffer storage and the shift register hold data only; no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= console_wdata[7:0];
    if (pop)  shift_q     <= mem[rd_ptr];
  end

endmodule

// File: tb/tb_console_tx.sv
// Self-checking bench for console_tx: random and directed writes against a frame-timeline model.
module tb_console_tx;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CPB   = 4;
`ifdef CONSOLE_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            console_we = 1'b0;
  logic [XLEN-1:0] console_wdata = '0;
  logic            full, idle, overflow, tx;
  logic [7:0]      drop_count;

  console_tx #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .console_we(console_we), .console_wdata(console_wdata),
    .full(full), .idle(idle), .overflow(overflow), .drop_count(drop_count), .tx(tx)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: queue of pending bytes plus remaining cycles of the frame on the wire.
  logic [7:0] mq[$];
  int         left;
  bit         fbits[NB];
  bit         m_full, m_ovf;
  int         m_drop;

  function automatic void model_reset();
    mq.delete();
    left   = 0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
    m_drop = 0;
  endfunction

  function automatic void load_frame(input logic [7:0] b);
    fbits[0] = 1'b0;
    for (int i = 0; i < 8; i++) fbits[i+1] = b[i];
`ifdef CONSOLE_TX_PARITY_EN
    fbits[9] = ^b;
`endif
    fbits[NB-1] = 1'b1;
  endfunction

  function automatic void model_edge(input bit we, input logic [31:0] d);
    bit full_pre;
    full_pre = m_full;
    if (mq.size() > 0 && left <= 1) begin
      load_frame(mq.pop_front());
      left = FRAME;
    end else if (left > 0) begin
      left--;
    end
    if (we) begin
      if (!full_pre) mq.push_back(d[7:0]);
      else begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
    m_full = (mq.size() == DEPTH);
  endfunction

  function automatic bit exp_tx();
    if (left == 0) return 1'b1;
    return fbits[(FRAME - left) / CPB];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("tx", 32'(tx), 32'(exp_tx()));
    check("idle", 32'(idle), 32'(left == 0 && mq.size() == 0));
    check("full", 32'(full), 32'(m_full));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("drop_count", 32'(drop_count), 32'(m_drop));
  endtask

  task automatic tick(input bit we, input logic [31:0] d);
    console_we    = we;
    console_wdata = d;
    @(posedge clk);
    model_edge(we, d);
    #1;
    check_all();
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, $urandom);
  endtask

  task automatic apply_reset();
    console_we = 1'b0;
    reset      = 1'b0;
    #1;
    model_reset();
    check("reset_tx", 32'(tx), 32'd1);
    check_all();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b1;

    // Quiet line after reset
    idle_ticks(100);

    // Single 'A' with random upper bits
    tick(1'b1, {$urandom_range(0, 16'hFFFF), 16'h0041});
    tick(1'b0, 32'd0);
    check("start_bit", 32'(tx), 32'd0);
    idle_ticks(FRAME + 10);

    // Four back-to-back bytes, contiguous frames
    for (int i = 0; i < 4; i++) tick(1'b1, 32'h31 + 32'(i));
    idle_ticks(4 * FRAME + 10);

    // Six back-to-back random bytes: one drop
    for (int i = 0; i < 6; i++) tick(1'b1, $urandom);
    check("one_drop", 32'(drop_count), 32'd1);
    idle_ticks(5 * FRAME + 10);

    // Parity-sensitive bytes
    tick(1'b1, 32'h07);
    tick(1'b1, 32'h03);
    idle_ticks(2 * FRAME + 10);

    // Sustained writes while full: drop counter saturates
    for (int i = 0; i < 400; i++) tick(1'b1, $urandom);
    check("drop_sat", 32'(drop_count), 32'd255);
    check("ovf_sticky", 32'(overflow), 32'd1);
    idle_ticks(DEPTH * FRAME + 10);

    // Reset in the middle of the data bits of 0x55 with two bytes queued
    apply_reset();
    tick(1'b1, 32'h55);
    tick(1'b1, $urandom);
    tick(1'b1, $urandom);
    idle_ticks(8);
    apply_reset();
    idle_ticks(3 * FRAME);
    check("post_reset_idle", 32'(idle), 32'd1);

    // Random traffic
    for (int i = 0; i < 1500; i++) tick($urandom_range(0, 9) < 3, $urandom);
    idle_ticks(DEPTH * FRAME + 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
